// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: fixed-latency MUL/MULH/MULHSU/MULHU and
// restoring radix-2 DIV/DIVU/REM/REMU, with pipeline hold and flush support.
module ex_muldiv #(
    parameter  int unsigned XLEN    = 32,
    parameter  int unsigned MUL_LAT = 2,
    localparam int unsigned CNT_W   = $clog2(XLEN + 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            hold_flag_o,
    output logic            done_o,
    output logic            rd_wr_en_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]      func3_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [4:0]      rd_q, rd_addr_q;
    logic [XLEN-1:0] result_q;
    logic            done_q;

    // Operand preparation at start: absolute values for signed divides.
    logic            op1_neg_i, op2_neg_i;
    logic [XLEN-1:0] op1_abs_i, op2_abs_i;

    always_comb begin
        op1_neg_i = !func3_i[0] && op1_i[XLEN-1];
        op2_neg_i = !func3_i[0] && op2_i[XLEN-1];
        op1_abs_i = op1_neg_i ? -op1_i : op1_i;
        op2_abs_i = op2_neg_i ? -op2_i : op2_i;
    end

    // Full product computed modulo 2^(2*XLEN) on sign/zero-extended operands.
    logic              op1_sx, op2_sx;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        op1_sx  = (func3_q == 2'b01 || func3_q == 2'b10) && op1_q[XLEN-1];
        op2_sx  = (func3_q == 2'b01) && op2_q[XLEN-1];
        mul_a   = {{XLEN{op1_sx}}, op1_q};
        mul_b   = {{XLEN{op2_sx}}, op2_q};
        mul_p   = mul_a * mul_b;
        mul_res = (func3_q == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end

    // One restoring step: the trial difference always fits XLEN bits when taken.
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff, rem_d, quo_d;

    always_comb begin
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, dvs_q};
        div_diff  = div_shift[XLEN-1:0] - dvs_q;
        rem_d     = div_ge ? div_diff : div_shift[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], div_ge};
    end

    logic            fix_signed, fix_ovf;
    logic [XLEN-1:0] fix_q, fix_r, fix_res;

    always_comb begin
        fix_signed = !func3_q[0];
        fix_ovf    = fix_signed && (op1_q == {1'b1, {(XLEN-1){1'b0}}}) && (op2_q == '1);
        fix_q      = (fix_signed && (op1_q[XLEN-1] ^ op2_q[XLEN-1])) ? -quo_q : quo_q;
        fix_r      = (fix_signed && op1_q[XLEN-1]) ? -rem_q : rem_q;
        if (op2_q == '0) begin
            fix_q = '1;
            fix_r = op1_q;
        end else if (fix_ovf) begin
            fix_q = op1_q;
            fix_r = '0;
        end
        fix_res = func3_q[1] ? fix_r : fix_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            func3_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rd_q      <= '0;
            rd_addr_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !kill_i) begin
                        func3_q <= func3_i[1:0];
                        op1_q   <= op1_i;
                        op2_q   <= op2_i;
                        rd_q    <= rd_addr_i;
                        rem_q   <= '0;
                        quo_q   <= op1_abs_i;
                        dvs_q   <= op2_abs_i;
                        if (func3_i[2]) begin
                            state_q <= S_DIV;
                            cnt_q   <= CNT_W'(XLEN - 1);
                        end else begin
                            state_q <= S_MUL;
                            cnt_q   <= CNT_W'(MUL_LAT - 1);
                        end
                    end
                end
                S_MUL: begin
                    if (kill_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        result_q  <= mul_res;
                        rd_addr_q <= rd_q;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    if (kill_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        if (cnt_q == '0) state_q <= S_FIX;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    if (kill_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q  <= fix_res;
                        rd_addr_q <= rd_q;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign hold_flag_o = ((state_q == S_IDLE) && start_i) || (state_q == S_MUL) ||
                         (state_q == S_DIV) || (state_q == S_FIX);
    assign done_o      = done_q;
    assign rd_wr_en_o  = done_q;
    assign rd_addr_o   = rd_addr_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: results, fixed latency, hold, kill and async reset.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd = '0;
    logic        busy, hold, done, wr_en;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    int done_seen;

    ex_muldiv #(.XLEN(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .start_i(start), .func3_i(f3), .op1_i(a), .op2_i(b),
        .rd_addr_i(rd), .kill_i(kill), .busy_o(busy), .hold_flag_o(hold),
        .done_o(done), .rd_wr_en_o(wr_en), .rd_addr_o(rd_out), .result_o(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op and checks hold/done timing plus result; lat = edges after E0.
    task automatic do_op(input string tag, input logic [2:0] fn, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] r,
                         input logic [31:0] exp, input int lat);
        @(negedge clk);
        f3 = fn; a = x; b = y; rd = r; start = 1'b1;
        #1;
        chk({tag, ".hold0"}, 32'(hold), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".nodone"}, 32'(done), 32'd0);
            chk({tag, ".hold"}, 32'(hold), 32'd1);
        end
        @(posedge clk);
        #1;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, ".hold_done"}, 32'(hold), 32'd0);
        chk({tag, ".result"}, result, exp);
        chk({tag, ".rd"}, 32'(rd_out), 32'(r));
        @(posedge clk);
        #1;
        chk({tag, ".done_drop"}, 32'(done), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".held"}, result, exp);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.hold", 32'(hold), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.wr_en", 32'(wr_en), 32'd0);
        chk("rst.rd", 32'(rd_out), 32'd0);
        chk("rst.result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2);
        do_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 2);
        do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 2);
        do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 2);
        do_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33);
        do_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33);
        do_op("divu",   3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       33);
        do_op("remu",   3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        33);
        do_op("divu0",  3'd5, 32'h1234,     32'd0,        5'd13, 32'hFFFFFFFF, 33);
        do_op("remu0",  3'd7, 32'h1234,     32'd0,        5'd14, 32'h1234,     33);
        do_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 33);
        do_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        33);
        do_op("div0s",  3'd4, 32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFFF, 33);
        do_op("rem0s",  3'd6, 32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFF9, 33);
        do_op("divmix", 3'd4, 32'd100,      32'hFFFFFFF9, 5'd19, 32'hFFFFFFF2, 33);
        do_op("remmix", 3'd6, 32'd100,      32'hFFFFFFF9, 5'd20, 32'd2,        33);

        // Kill a divide at cycle 10, with an ignored start pulse while busy.
        @(negedge clk);
        f3 = 3'd4; a = 32'd1000; b = 32'd3; rd = 5'd21; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; f3 = 3'd0;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busystart.busy", 32'(busy), 32'd1);
        chk("busystart.hold", 32'(hold), 32'd1);
        chk("busystart.done", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        chk("kill.busy", 32'(busy), 32'd0);
        chk("kill.hold", 32'(hold), 32'd0);
        chk("kill.done", 32'(done), 32'd0);
        do_op("mulafterkill", 3'd0, 32'd6, 32'd7, 5'd22, 32'd42, 2);

        // Start together with kill in idle is refused.
        @(negedge clk);
        f3 = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        chk("killstart.busy", 32'(busy), 32'd0);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (done) done_seen++;
        end
        chk("killstart.nodone", 32'(done_seen), 32'd0);

        // Kill on the final multiply cycle suppresses the done pulse.
        @(negedge clk);
        f3 = 3'd0; a = 32'd9; b = 32'd9; rd = 5'd23; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        chk("killmul.done", 32'(done), 32'd0);
        chk("killmul.busy", 32'(busy), 32'd0);
        chk("killmul.result", result, 32'd42);

        // Kill during DONE still delivers the pulse.
        @(negedge clk);
        f3 = 3'd0; a = 32'd5; b = 32'd5; rd = 5'd24; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("killdone.done", 32'(done), 32'd1);
        chk("killdone.result", result, 32'd25);
        @(negedge clk);
        kill = 1'b1;
        #1;
        chk("killdone.still", 32'(done), 32'd1);
        @(posedge clk);
        #1 kill = 1'b0;
        chk("killdone.idle", 32'(busy), 32'd0);
        chk("killdone.drop", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        f3 = 3'd5; a = 32'd500; b = 32'd5; rd = 5'd25; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.hold", 32'(hold), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.wr_en", 32'(wr_en), 32'd0);
        chk("midrst.rd", 32'(rd_out), 32'd0);
        chk("midrst.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) done_seen++;
        end
        chk("midrst.nodone", 32'(done_seen), 32'd0);
        do_op("mulafterrst", 3'd0, 32'd3, 32'd4, 5'd26, 32'd12, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
